// File: rtl/spi_transaction_arbiter.sv
// Purpose: arbitrates host requests and periodic poll readbacks onto one SPI controller port.
// Latency: request seen in IDLE at N -> spi_start at N+1; spi_done at N+2 -> done pulse at N+3.
// Backpressure: host holds host_req_valid until host_grant; poll requests queue at depth one.
module spi_transaction_arbiter #(
    parameter int unsigned POLL_PERIOD    = 100000,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic       axi_clk,
    input  logic       reset_b,
    // host request channel
    input  logic       host_req_valid,
    input  logic       host_WnR,
    input  logic [9:0] host_addr,
    input  logic [7:0] host_len,
    output logic       host_grant,
    output logic       host_done,
    // periodic readback channel
    input  logic       poll_en,
    input  logic [9:0] poll_addr,
    input  logic [7:0] poll_len,
    output logic       poll_done,
    // SPI controller side
    output logic       WnR,
    output logic [9:0] spi_address,
    output logic [7:0] spi_data_len,
    output logic       spi_start,
    input  logic       spi_done,
    // status
    output logic       busy,
    output logic       owner,
    output logic       timeout_err,
    input  logic       err_clr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        COMPLETE  = 2'd3
    } state_t;

    localparam logic [23:0] LP_POLL_MAX = 24'(POLL_PERIOD - 1);
    localparam logic [19:0] LP_TO_MAX   = 20'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next_state;

    logic [23:0] r_poll_cnt;
    logic        r_poll_pending;
    logic [19:0] r_to_cnt;
    logic [19:0] w_to_next;
    logic        r_timeout_err;
    logic        r_last_owner;
    logic        r_owner;
    logic        r_wnr;
    logic [9:0]  r_addr;
    logic [7:0]  r_len;

    logic        w_host_win;
    logic        w_poll_win;
    logic        w_timeout;
    logic        w_spi_start;
    logic        w_host_grant;
    logic        w_host_done;
    logic        w_poll_done;

    // Round-robin only matters on a tie: the side not served last goes first.
    assign w_host_win = (r_state == IDLE) && host_req_valid && (!r_poll_pending || r_last_owner);
    assign w_poll_win = (r_state == IDLE) && r_poll_pending && (!host_req_valid || !r_last_owner);

    // The timeout fires on the wait cycle whose increment would bring the counter to
    // TIMEOUT_CYCLES-1, so the error and COMPLETE appear TIMEOUT_CYCLES cycles after ISSUE.
    assign w_to_next = r_to_cnt + 20'd1;
    assign w_timeout = (r_state == WAIT_DONE) && !spi_done && (w_to_next == LP_TO_MAX);

    // State register.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next_state = r_state;
        w_spi_start  = 1'b0;
        w_host_grant = 1'b0;
        w_host_done  = 1'b0;
        w_poll_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_host_win || w_poll_win) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                w_spi_start  = 1'b1;
                w_host_grant = !r_owner;
                w_next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (spi_done || w_timeout) begin
                    w_next_state = COMPLETE;
                end
            end
            COMPLETE: begin
                w_host_done  = !r_owner;
                w_poll_done  = r_owner;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Latch the winner's transaction fields and ownership when leaving IDLE.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_wnr        <= 1'b0;
            r_addr       <= '0;
            r_len        <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else if (w_host_win) begin
            r_wnr        <= host_WnR;
            r_addr       <= host_addr;
            r_len        <= host_len;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
        end else if (w_poll_win) begin
            r_wnr        <= 1'b0;           // polls are always readbacks
            r_addr       <= poll_addr;
            r_len        <= poll_len;
            r_owner      <= 1'b1;
            r_last_owner <= 1'b1;
        end
    end

    // Poll timer; a wrap on the same edge the poll is taken re-arms the request.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_poll_cnt     <= '0;
            r_poll_pending <= 1'b0;
        end else if (!poll_en) begin
            r_poll_cnt     <= '0;
            r_poll_pending <= 1'b0;
        end else if (r_poll_cnt == LP_POLL_MAX) begin
            r_poll_cnt     <= '0;
            r_poll_pending <= 1'b1;
        end else begin
            r_poll_cnt <= r_poll_cnt + 24'd1;
            if (w_poll_win) begin
                r_poll_pending <= 1'b0;
            end
        end
    end

    // Timeout counter: cleared while issuing, advances on each wait cycle without spi_done.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_to_cnt <= '0;
        end else if (r_state == ISSUE) begin
            r_to_cnt <= '0;
        end else if ((r_state == WAIT_DONE) && !spi_done) begin
            r_to_cnt <= w_to_next;
        end
    end

    // Sticky timeout flag; a timeout on the same edge as err_clr keeps the flag set.
    always_ff @(posedge axi_clk or negedge reset_b) begin
        if (!reset_b) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign spi_start    = w_spi_start;
    assign host_grant   = w_host_grant;
    assign host_done    = w_host_done;
    assign poll_done    = w_poll_done;
    assign busy         = (r_state != IDLE);
    assign owner        = r_owner;
    assign WnR          = r_wnr;
    assign spi_address  = r_addr;
    assign spi_data_len = r_len;
    assign timeout_err  = r_timeout_err;

endmodule

// File: tb/tb_spi_transaction_arbiter.sv
// Purpose: directed bench for spi_transaction_arbiter with a short poll period and timeout.
// Latency: inputs change and outputs are sampled 1 time unit after each rising edge.
// Backpressure: the bench plays host and SPI controller, holding requests until granted.
module tb_spi_transaction_arbiter;

    localparam int unsigned PP = 10;
    localparam int unsigned TO = 8;

    logic       axi_clk = 1'b0;
    logic       reset_b;
    logic       host_req_valid;
    logic       host_WnR;
    logic [9:0] host_addr;
    logic [7:0] host_len;
    logic       host_grant;
    logic       host_done;
    logic       poll_en;
    logic [9:0] poll_addr;
    logic [7:0] poll_len;
    logic       poll_done;
    logic       WnR;
    logic [9:0] spi_address;
    logic [7:0] spi_data_len;
    logic       spi_start;
    logic       spi_done;
    logic       busy;
    logic       owner;
    logic       timeout_err;
    logic       err_clr;

    int n_checks = 0;
    int n_errors = 0;

    spi_transaction_arbiter #(
        .POLL_PERIOD    (PP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .axi_clk        (axi_clk),
        .reset_b        (reset_b),
        .host_req_valid (host_req_valid),
        .host_WnR       (host_WnR),
        .host_addr      (host_addr),
        .host_len       (host_len),
        .host_grant     (host_grant),
        .host_done      (host_done),
        .poll_en        (poll_en),
        .poll_addr      (poll_addr),
        .poll_len       (poll_len),
        .poll_done      (poll_done),
        .WnR            (WnR),
        .spi_address    (spi_address),
        .spi_data_len   (spi_data_len),
        .spi_start      (spi_start),
        .spi_done       (spi_done),
        .busy           (busy),
        .owner          (owner),
        .timeout_err    (timeout_err),
        .err_clr        (err_clr)
    );

    always #5 axi_clk = ~axi_clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge axi_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_b        = 1'b0;
        host_req_valid = 1'b0;
        host_WnR       = 1'b0;
        host_addr      = '0;
        host_len       = '0;
        poll_en        = 1'b0;
        poll_addr      = '0;
        poll_len       = '0;
        spi_done       = 1'b0;
        err_clr        = 1'b0;
        #2;

        // ---------------- reset state ----------------
        chk("rst_busy",   32'(busy),         32'd0);
        chk("rst_start",  32'(spi_start),    32'd0);
        chk("rst_grant",  32'(host_grant),   32'd0);
        chk("rst_hdone",  32'(host_done),    32'd0);
        chk("rst_pdone",  32'(poll_done),    32'd0);
        chk("rst_owner",  32'(owner),        32'd0);
        chk("rst_err",    32'(timeout_err),  32'd0);
        chk("rst_addr",   32'(spi_address),  32'd0);
        chk("rst_len",    32'(spi_data_len), 32'd0);
        step(2);
        reset_b = 1'b1;
        step(1);
        chk("idle_busy",  32'(busy),         32'd0);

        // ---------------- tie, two rounds: host then poll ----------------
        poll_addr = 10'h3C0;
        poll_len  = 8'd16;
        poll_en   = 1'b1;                   // timer wraps after PP cycles
        step(10);
        chk("tie_pre_busy", 32'(busy), 32'd0);
        host_req_valid = 1'b1;
        host_WnR       = 1'b0;
        host_addr      = 10'h0A5;
        host_len       = 8'd8;
        spi_done       = 1'b1;
        step(1);
        chk("tie1_owner", 32'(owner),       32'd0);
        chk("tie1_grant", 32'(host_grant),  32'd1);
        chk("tie1_start", 32'(spi_start),   32'd1);
        chk("tie1_addr",  32'(spi_address), 32'h0A5);
        host_req_valid = 1'b0;
        step(2);
        chk("tie1_hdone", 32'(host_done),   32'd1);
        host_req_valid = 1'b1;              // second tie in the following IDLE
        step(1);
        chk("tie2_idle",  32'(busy),        32'd0);
        step(1);
        chk("tie2_owner", 32'(owner),        32'd1);
        chk("tie2_start", 32'(spi_start),    32'd1);
        chk("tie2_grant", 32'(host_grant),   32'd0);
        chk("tie2_addr",  32'(spi_address),  32'h3C0);
        chk("tie2_len",   32'(spi_data_len), 32'd16);
        chk("tie2_wnr",   32'(WnR),          32'd0);
        step(2);
        chk("tie2_pdone", 32'(poll_done),   32'd1);
        chk("tie2_hdone", 32'(host_done),   32'd0);
        step(2);
        chk("tie3_owner", 32'(owner),       32'd0);
        chk("tie3_grant", 32'(host_grant),  32'd1);
        host_req_valid = 1'b0;
        poll_en        = 1'b0;
        step(2);
        chk("tie3_hdone", 32'(host_done),   32'd1);
        step(2);
        chk("tie_end_busy", 32'(busy),      32'd0);

        // ---------------- host write with late spi_done ----------------
        spi_done       = 1'b0;
        host_req_valid = 1'b1;
        host_WnR       = 1'b1;
        host_addr      = 10'h155;
        host_len       = 8'd32;
        step(1);
        chk("hw_grant", 32'(host_grant),   32'd1);
        chk("hw_start", 32'(spi_start),    32'd1);
        chk("hw_wnr",   32'(WnR),          32'd1);
        chk("hw_addr",  32'(spi_address),  32'h155);
        chk("hw_len",   32'(spi_data_len), 32'd32);
        chk("hw_owner", 32'(owner),        32'd0);
        host_req_valid = 1'b0;
        step(1);
        chk("hw_grant_once", 32'(host_grant), 32'd0);
        chk("hw_start_once", 32'(spi_start),  32'd0);
        chk("hw_busy",       32'(busy),       32'd1);
        step(3);
        chk("hw_hold_addr", 32'(spi_address),  32'h155);
        chk("hw_hold_len",  32'(spi_data_len), 32'd32);
        step(1);
        spi_done = 1'b1;                    // 5 cycles after spi_start
        chk("hw_no_early_done", 32'(host_done), 32'd0);
        step(1);
        chk("hw_hdone", 32'(host_done), 32'd1);
        chk("hw_pdone", 32'(poll_done), 32'd0);
        spi_done = 1'b0;
        step(1);
        chk("hw_idle",      32'(busy),        32'd0);
        chk("hw_hdone_end", 32'(host_done),   32'd0);
        // stray spi_done in IDLE is ignored; fields hold their last value
        spi_done  = 1'b1;
        host_addr = 10'h2AA;
        step(2);
        chk("stray_done_busy",  32'(busy),        32'd0);
        chk("stray_done_hdone", 32'(host_done),   32'd0);
        chk("idle_hold_addr",   32'(spi_address), 32'h155);

        // ---------------- periodic poll, spi_done returned at once ----------------
        poll_en = 1'b1;
        step(10);
        chk("poll0_pre", 32'(spi_start), 32'd0);
        step(1);
        chk("poll0_start", 32'(spi_start),    32'd1);
        chk("poll0_owner", 32'(owner),        32'd1);
        chk("poll0_addr",  32'(spi_address),  32'h3C0);
        chk("poll0_len",   32'(spi_data_len), 32'd16);
        for (int k = 1; k < 3; k++) begin
            step(9);
            chk("pollk_pre", 32'(spi_start), 32'd0);
            step(1);
            chk("pollk_start", 32'(spi_start),   32'd1);
            chk("pollk_owner", 32'(owner),       32'd1);
            chk("pollk_addr",  32'(spi_address), 32'h3C0);
        end
        // poll_en falls while this poll is in flight: it still completes
        spi_done = 1'b0;
        poll_en  = 1'b0;
        step(2);
        chk("pabort_busy",  32'(busy),      32'd1);
        chk("pabort_pdone", 32'(poll_done), 32'd0);
        spi_done = 1'b1;
        step(1);
        chk("pabort_done",  32'(poll_done), 32'd1);
        spi_done = 1'b0;
        step(1);
        chk("pabort_idle",  32'(busy),      32'd0);
        step(12);
        chk("poll_off_busy", 32'(busy),     32'd0);

        // ---------------- timeout ----------------
        host_req_valid = 1'b1;
        host_WnR       = 1'b0;
        host_addr      = 10'h011;
        host_len       = 8'd8;
        step(1);
        chk("to_grant", 32'(host_grant), 32'd1);
        host_req_valid = 1'b0;
        step(7);
        chk("to_err_early", 32'(timeout_err), 32'd0);
        chk("to_busy",      32'(busy),        32'd1);
        step(1);
        chk("to_err",   32'(timeout_err), 32'd1);
        chk("to_hdone", 32'(host_done),   32'd1);
        step(1);
        chk("to_idle",   32'(busy),        32'd0);
        chk("to_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        step(1);
        chk("to_clr", 32'(timeout_err), 32'd0);
        err_clr = 1'b0;
        // err_clr held across a second timeout: the set wins
        host_req_valid = 1'b1;
        step(1);
        host_req_valid = 1'b0;
        err_clr        = 1'b1;
        step(7);
        chk("to2_err_early", 32'(timeout_err), 32'd0);
        step(1);
        chk("to2_set_wins", 32'(timeout_err), 32'd1);
        err_clr = 1'b0;
        step(1);
        chk("to2_sticky", 32'(timeout_err), 32'd1);
        err_clr = 1'b1;
        step(1);
        chk("to2_clr", 32'(timeout_err), 32'd0);
        err_clr = 1'b0;

        // ---------------- reset during WAIT_DONE ----------------
        host_req_valid = 1'b1;
        host_WnR       = 1'b1;
        host_addr      = 10'h0F0;
        host_len       = 8'd12;
        step(1);
        host_req_valid = 1'b0;
        step(2);
        chk("rw_busy", 32'(busy), 32'd1);
        reset_b        = 1'b0;
        host_req_valid = 1'b1;
        host_addr      = 10'h1E1;
        spi_done       = 1'b1;
        #1;
        chk("rw_async_busy",  32'(busy),         32'd0);
        chk("rw_async_addr",  32'(spi_address),  32'd0);
        chk("rw_async_len",   32'(spi_data_len), 32'd0);
        chk("rw_async_wnr",   32'(WnR),          32'd0);
        chk("rw_async_owner", 32'(owner),        32'd0);
        chk("rw_async_start", 32'(spi_start),    32'd0);
        step(3);
        chk("rw_no_hdone", 32'(host_done), 32'd0);
        chk("rw_held",     32'(busy),      32'd0);
        spi_done = 1'b0;
        reset_b  = 1'b1;
        step(1);
        chk("rw_first_grant", 32'(host_grant),  32'd1);
        chk("rw_first_start", 32'(spi_start),   32'd1);
        chk("rw_first_addr",  32'(spi_address), 32'h1E1);
        host_req_valid = 1'b0;
        step(1);
        spi_done = 1'b1;
        step(1);
        chk("rw_hdone", 32'(host_done), 32'd1);
        spi_done = 1'b0;
        step(1);
        chk("rw_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_transaction_arbiter.md
SPI_TRANSACTION_ARBITER -- requirements
Module: spi_transaction_arbiter

Interface
REQ-001 Parameter POLL_PERIOD, default 100000, the poll interval in axi_clk cycles; legal range 2..2^24-1.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535, the maximum wait for spi_done in axi_clk cycles; legal range 2..2^20-1.
REQ-003 axi_clk  in  1  single clock; all logic is on the rising edge.
REQ-004 reset_b  in  1  asynchronous, active-low reset.
REQ-005 host_req_valid  in  1  host transaction request, held high until host_grant.
REQ-006 host_WnR / host_addr / host_len  in  1/10/8  host write-not-read flag, SPI register address, and data length in bits.
REQ-007 host_grant  out  1  one-cycle pulse that accepts the host request.
REQ-008 host_done  out  1  one-cycle pulse that ends the host transaction.
REQ-009 poll_en / poll_addr / poll_len  in  1/10/8  periodic readback enable, address, and length.
REQ-010 poll_done  out  1  one-cycle pulse that ends a poll transaction.
REQ-011 WnR / spi_address / spi_data_len  out  1/10/8  transaction fields driven to the SPI controller.
REQ-012 spi_start  out  1  one-cycle strobe to the SPI controller.
REQ-013 spi_done  in  1  transaction-complete signal from the SPI controller.
REQ-014 busy / owner  out  1/1  busy is high whenever the block is not IDLE; owner is 0 for host and 1 for poll.
REQ-015 timeout_err  out  1  sticky timeout flag; err_clr  in  1  clears it.

Function
REQ-016 The FSM SHALL have four states: IDLE, ISSUE, WAIT_DONE, COMPLETE.
REQ-017 Poll timer:
- While poll_en=1, the timer counts 0..POLL_PERIOD-1 and wraps to 0.
- On wrap, poll_pending is set; a wrap while poll_pending is already set SHALL NOT queue a second request.
- poll_en=0 clears the timer and poll_pending.
REQ-018 IDLE arbitration:
- Candidates are host_req_valid and poll_pending.
- With a single candidate, that candidate wins.
- With both candidates, round-robin: the requester not served last wins; last_owner resets to 1, so the host wins the first tie.
REQ-019 On the IDLE->ISSUE edge, the block SHALL:
- latch the winner's WnR, addr, and len into WnR, spi_address, and spi_data_len;
- update owner and last_owner;
- clear poll_pending if poll won.
REQ-020 ISSUE SHALL last exactly one cycle and SHALL assert spi_start, plus host_grant if owner=0; the next state is WAIT_DONE and the timeout counter is cleared.
REQ-021 In WAIT_DONE:
- spi_done=1 -> COMPLETE.
- Otherwise the timeout counter increments.
- When the counter reaches TIMEOUT_CYCLES-1 without spi_done, the block SHALL set timeout_err and go to COMPLETE.
REQ-022 COMPLETE SHALL last one cycle, pulse host_done or poll_done according to owner, then return to IDLE.
REQ-023 WnR, spi_address, spi_data_len, and owner SHALL hold their values from ISSUE through COMPLETE, and SHALL keep their last values while in IDLE.
REQ-024 Latency:
- A request seen in IDLE at cycle N gives ISSUE at N+1.
- spi_done at N+2 gives COMPLETE at N+3 and IDLE at N+4.
- The earliest next ISSUE is N+5.
REQ-025 spi_done SHALL be ignored outside WAIT_DONE; a host_req_valid deassertion before grant withdraws the request.
REQ-026 poll_en falling during an in-flight poll transaction SHALL NOT abort it; the transaction completes and poll_done pulses.
REQ-027 err_clr clears timeout_err; if err_clr coincides with a timeout, the set SHALL win.
REQ-028 New timer wraps during a transaction SHALL set poll_pending normally.

Reset
REQ-029 While reset_b=0, the block SHALL immediately:
- enter IDLE;
- drive all outputs to 0;
- clear the poll timer, poll_pending, the timeout counter, and timeout_err;
- set last_owner to 1.
REQ-030 Reset assertion mid-transaction SHALL abort the transaction with no done pulse.
REQ-031 The first arbitration SHALL occur on the first rising edge after reset_b rises.

Verification
REQ-032 Host write: host_req_valid=1, host_WnR=1, addr=0x155, len=32; spi_done 5 cycles after spi_start -> single host_grant and spi_start in the same cycle, fields stable, host_done one cycle after spi_done.
REQ-033 Tie: host_req_valid and poll_pending both high in IDLE, for two rounds -> host is served first, then poll; owner sequence 0,1.
REQ-034 Poll with POLL_PERIOD=10, poll_len=16, spi_done always returned immediately -> spi_start every 10 cycles with spi_address=poll_addr and owner=1.
REQ-035 Timeout with TIMEOUT_CYCLES=8 and spi_done never asserted -> timeout_err rises 8 cycles after ISSUE, host_done pulses, busy falls; err_clr pulse -> timeout_err=0.
REQ-036 Reset asserted in WAIT_DONE -> outputs go to 0 asynchronously, no host_done; after release, a pending host request is granted first.
